// File: rtl/eco32_core_lsu_dcu_ptc_pkg.sv
// ============================================================================
// Module   : eco32_core_lsu_dcu_ptc_pkg
// Brief    : Shared types and constants for the DCU page-table controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package eco32_core_lsu_dcu_ptc_pkg;

    localparam int DESC_WIDTH = 39;

    localparam logic [DESC_WIDTH-1:0] DESC_INVALID = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INIT  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } ptc_state_e;

endpackage

`default_nettype wire

// File: rtl/eco32_core_lsu_dcu_ptc.sv
// ============================================================================
// Module   : eco32_core_lsu_dcu_ptc
// Brief    : DCU page-table controller: registers refills into the table and
//            sweeps it to invalid on flush (and after reset when
//            ECO32_DCU_PT_INIT_FLUSH_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module eco32_core_lsu_dcu_ptc
    import eco32_core_lsu_dcu_ptc_pkg::*;
#(
    parameter int PAGE_ADDR_WIDTH = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rf_stb,
    input  logic                       rf_tid,
    input  logic [PAGE_ADDR_WIDTH-1:0] rf_page,
    input  logic [DESC_WIDTH-1:0]      rf_descriptor,
    output logic                       rf_ack,
    input  logic                       fl_req,
    input  logic                       fl_all,
    input  logic                       fl_tid,
    output logic                       fl_done,
    output logic                       o_busy,
    output logic                       wr_ena,
    output logic                       wr_tid,
    output logic [PAGE_ADDR_WIDTH-1:0] wr_page,
    output logic [DESC_WIDTH-1:0]      wr_descriptor
);

    localparam int CW = PAGE_ADDR_WIDTH + 1;
    localparam logic [CW-1:0] LAST_ALL = {CW{1'b1}};
    localparam logic [CW-1:0] LAST_ONE = {1'b0, {PAGE_ADDR_WIDTH{1'b1}}};

`ifdef ECO32_DCU_PT_INIT_FLUSH_EN
    localparam ptc_state_e RST_STATE = ST_INIT;
`else
    localparam ptc_state_e RST_STATE = ST_IDLE;
`endif

    ptc_state_e                 state_q, state_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       all_q, all_d;
    logic                       tid_q, tid_d;
    logic                       wr_ena_q, wr_ena_d;
    logic                       wr_tid_q, wr_tid_d;
    logic [PAGE_ADDR_WIDTH-1:0] wr_page_q, wr_page_d;
    logic [DESC_WIDTH-1:0]      wr_desc_q, wr_desc_d;
    logic                       fl_done_q, fl_done_d;

    logic sweep_all;
    logic sweep_last;

    // The power-on sweep always covers both threads regardless of captured fl_all.
    assign sweep_all  = all_q | (state_q == ST_INIT);
    assign sweep_last = sweep_all ? (cnt_q == LAST_ALL) : (cnt_q == LAST_ONE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        all_d     = all_q;
        tid_d     = tid_q;
        wr_ena_d  = 1'b0;
        wr_tid_d  = wr_tid_q;
        wr_page_d = wr_page_q;
        wr_desc_d = wr_desc_q;
        fl_done_d = 1'b0;
        rf_ack    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                rf_ack = rf_stb;
                // A refill in the same cycle as fl_req is written before the sweep starts.
                if (rf_stb) begin
                    wr_ena_d  = 1'b1;
                    wr_tid_d  = rf_tid;
                    wr_page_d = rf_page;
                    wr_desc_d = rf_descriptor;
                end
                if (fl_req) begin
                    all_d   = fl_all;
                    tid_d   = fl_tid;
                    cnt_d   = '0;
                    state_d = ST_FLUSH;
                end
            end
            ST_INIT, ST_FLUSH: begin
                wr_ena_d  = 1'b1;
                wr_desc_d = DESC_INVALID;
                if (sweep_all) begin
                    wr_tid_d  = cnt_q[0];
                    wr_page_d = cnt_q[CW-1:1];
                end else begin
                    wr_tid_d  = tid_q;
                    wr_page_d = cnt_q[PAGE_ADDR_WIDTH-1:0];
                end
                if (sweep_last) begin
                    cnt_d     = '0;
                    state_d   = (state_q == ST_INIT) ? ST_IDLE : ST_DONE;
                    fl_done_d = (state_q == ST_FLUSH);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RST_STATE;
            cnt_q     <= '0;
            all_q     <= 1'b0;
            tid_q     <= 1'b0;
            wr_ena_q  <= 1'b0;
            wr_tid_q  <= 1'b0;
            wr_page_q <= '0;
            wr_desc_q <= '0;
            fl_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            all_q     <= all_d;
            tid_q     <= tid_d;
            wr_ena_q  <= wr_ena_d;
            wr_tid_q  <= wr_tid_d;
            wr_page_q <= wr_page_d;
            wr_desc_q <= wr_desc_d;
            fl_done_q <= fl_done_d;
        end
    end

    assign o_busy        = (state_q == ST_INIT) || (state_q == ST_FLUSH);
    assign fl_done       = fl_done_q;
    assign wr_ena        = wr_ena_q;
    assign wr_tid        = wr_tid_q;
    assign wr_page       = wr_page_q;
    assign wr_descriptor = wr_desc_q;

endmodule

`default_nettype wire

// File: doc/eco32_core_lsu_dcu_ptc.md
ECO32_CORE_LSU_DCU_PTC -- requirements
Module: eco32_core_lsu_dcu_ptc

Interface
REQ-001 SHALL have parameter PAGE_ADDR_WIDTH, default 5, page index width; table depth is 2^(PAGE_ADDR_WIDTH+1) (2 threads).
REQ-002 SHALL have ports as listed; one clock; reset is asynchronous and active-high:
  clk  in  1  clock, all state on rising edge
  rst  in  1  reset, asynchronous, active-high
  rf_stb  in  1  refill request valid
  rf_tid  in  1  refill thread id
  rf_page  in  PAGE_ADDR_WIDTH  refill page index
  rf_descriptor  in  39  refill descriptor
  rf_ack  out  1  refill accepted this cycle (combinational)
  fl_req  in  1  flush request, level, sampled in IDLE only
  fl_all  in  1  1 = flush both threads, 0 = flush fl_tid only
  fl_tid  in  1  thread to flush when fl_all=0
  fl_done  out  1  one-cycle pulse, flush complete
  o_busy  out  1  flush/init in progress
  wr_ena  out  1  table write enable
  wr_tid  out  1  table write thread id
  wr_page  out  PAGE_ADDR_WIDTH  table write page
  wr_descriptor  out  39  table write data

Function
REQ-003 SHALL implement FSM states IDLE, INIT, FLUSH, DONE.
REQ-004 IDLE: rf_ack = rf_stb; FLUSH/INIT/DONE: rf_ack = 0 (refills stall, never dropped).
REQ-005 Accepted refill in cycle N SHALL produce wr_ena=1 with captured tid/page/descriptor in cycle N+1 (registered, 1-cycle latency).
REQ-006 IDLE with fl_req=1 SHALL go to FLUSH next cycle; same-cycle rf_stb is accepted first (refill before flush), and its write occurs in first FLUSH cycle before sweep entry 0 (sweep starts one cycle later).
REQ-007 FLUSH SHALL write descriptor 39'd0 one entry per cycle, page counter 0 to 2^PAGE_ADDR_WIDTH-1; fl_all=1 iterates {page,tid} 0 to 2^(PAGE_ADDR_WIDTH+1)-1 with tid as LSB; fl_all=0 holds wr_tid=fl_tid captured at request.
REQ-008 fl_all/fl_tid SHALL be captured in IDLE on the fl_req cycle; later changes ignored.
REQ-009 After final sweep write, FSM SHALL enter DONE for one cycle asserting fl_done=1, then IDLE.
REQ-010 fl_req held high through DONE SHALL start a new flush from IDLE (no auto-retrigger inside DONE).
REQ-011 o_busy = 1 in INIT and FLUSH, 0 in IDLE and DONE.
REQ-012 Sweep counter width PAGE_ADDR_WIDTH+1, SHALL terminate by terminal-count compare, never wrap.

Reset
REQ-013 rst SHALL asynchronously force: wr_ena=0, wr_tid=0, wr_page=0, wr_descriptor=0, fl_done=0, counter=0.
REQ-014 After rst release, FSM SHALL enter INIT if ECO32_DCU_PT_INIT_FLUSH_EN defined, else IDLE; o_busy reset value follows state.
REQ-015 rst mid-flush SHALL abort the sweep; no fl_done pulse for aborted flush.

Configuration
REQ-016 Macro ECO32_DCU_PT_INIT_FLUSH_EN defined: INIT performs full 2-thread sweep (as fl_all=1) after reset, then IDLE with no fl_done pulse; fl_req ignored during INIT.
REQ-017 Macro undefined: INIT state unreachable, IDLE immediately after reset, table contents undefined until first flush.

Structure
REQ-018 Shared package SHALL hold FSM state encodings, descriptor width 39, invalid descriptor constant 39'd0.
REQ-019 No sub-module; sweep counter and FSM inline; write outputs drive eco32_core_lsu_dcu_pt wr_* ports directly.

Verification (PAGE_ADDR_WIDTH=5)
REQ-020 Macro defined, release rst -> o_busy=1 for 64 cycles, wr_ena=1 with {page,tid}=0..63, descriptor 0, no fl_done, then IDLE.
REQ-021 IDLE, rf_stb=1 tid=1 page=7 desc=39'h12_3456_789A -> rf_ack=1 same cycle; next cycle wr_ena=1, wr_tid=1, wr_page=7, wr_descriptor=39'h12_3456_789A.
REQ-022 fl_req=1 fl_all=0 fl_tid=1 -> 32 writes, wr_tid=1, pages 0..31, then fl_done=1 exactly 1 cycle; rf_stb during sweep -> rf_ack=0 until IDLE, then accepted.
REQ-023 fl_req and rf_stb same IDLE cycle -> refill write first cycle, sweep entries next 64 cycles (fl_all=1), fl_done after.
REQ-024 rst asserted at sweep entry 20 -> outputs zero immediately (async), no fl_done; restart per REQ-014.
